// File: rtl/alu_pkg.sv
// Shared ALU function codes, issue-stage state encoding and op classification
// helpers, reused by the ALU decode and writeback stages.
package alu_pkg;

  localparam logic [11:0] FUNCT_ADD = 12'h020;
  localparam logic [11:0] FUNCT_SUB = 12'h022;
  localparam logic [11:0] FUNCT_MUL = 12'h018;
  localparam logic [11:0] FUNCT_DIV = 12'h01A;
  localparam logic [11:0] FUNCT_REM = 12'h01B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_single_cycle(input logic [11:0] funct);
    return (funct == FUNCT_ADD) || (funct == FUNCT_SUB);
  endfunction

  function automatic logic is_multicycle(input logic [11:0] funct);
    return (funct == FUNCT_MUL) || (funct == FUNCT_DIV) || (funct == FUNCT_REM);
  endfunction

endpackage

// File: rtl/alu_issue_timer.sv
// Loadable up-counter that raises tc_o once it has counted TIMEOUT cycles
// (value TIMEOUT-1); it saturates there so it never wraps back to zero.
module alu_issue_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == TC_VAL);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Issue stage in front of the ALU: one operation in flight, operands held on
// the ALU inputs, multi-cycle ops started and awaited, result offered to writeback.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
// The producer keeps valid and its payload stable until that edge; ready may be
// driven independently of valid.
module alu_issue
  import alu_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      in_funct,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [11:0]      alu_funct,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic             alu_start,
  input  logic [31:0]      alu_c,
  input  logic             alu_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output state_e           dbg_state_o
);

  state_e           state_q, state_d;
  logic [11:0]      funct_q, funct_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      data_q, data_d;
  logic             err_q, err_d;
  logic             start;
  logic             tmr_load;
  logic             tmr_en;
  logic             tmr_tc;

  alu_issue_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i  (clk),
    .rst_ni (reset),
    .load_i (tmr_load),
    .en_i   (tmr_en),
    .tc_o   (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    funct_d  = funct_q;
    a_d      = a_q;
    b_d      = b_q;
    tag_d    = tag_q;
    data_d   = data_q;
    err_d    = err_q;
    start    = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          funct_d = in_funct;
          a_d     = in_a;
          b_d     = in_b;
          tag_d   = in_tag;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (is_single_cycle(funct_q)) begin
          data_d  = alu_c;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (!is_multicycle(funct_q)) begin
          data_d  = 32'h0;
          err_d   = 1'b1;
          state_d = DONE;
        end else if ((funct_q != FUNCT_MUL) && (b_q == 32'h0)) begin
          // Divide by zero never reaches the divider; report RISC-V style values.
          data_d  = (funct_q == FUNCT_DIV) ? 32'hFFFF_FFFF : a_q;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          start    = 1'b1;
          tmr_load = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        tmr_en = 1'b1;
        if (alu_ready) begin
          data_d  = alu_c;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (tmr_tc) begin
          data_d  = 32'h0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      funct_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      funct_q <= funct_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign alu_start   = start;
  assign alu_funct   = funct_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign out_data    = data_q;
  assign out_tag     = tag_q;
  assign out_err     = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: behavioural ALU, transaction-level model
// with an expected queue, per-cycle compare, directed and random operations.
module tb_alu_issue;
  import alu_pkg::*;

  localparam int TIMEOUT = 64;
  localparam int TAG_W   = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [11:0]      in_funct = '0;
  logic [31:0]      in_a = '0;
  logic [31:0]      in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [11:0]      alu_funct;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic             alu_start;
  logic [31:0]      alu_c;
  logic             alu_ready = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;
  state_e           dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  alu_issue #(.TIMEOUT(TIMEOUT), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct(in_funct),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .alu_funct(alu_funct), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
    .alu_c(alu_c), .alu_ready(alu_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_err(out_err), .dbg_state_o(dbg_state)
  );

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
    int               lat;
    int               starts;
  } exp_t;

  exp_t exp_q[$];

  // Stimulus controls, written only by the main initial block.
  int   cur_delay = 1;
  bit   stray_ready = 1'b0;
  bit   or_rand = 1'b0;
  bit   or_val = 1'b1;

  // Model / observation state, written only by the monitor.
  bit          busy = 1'b0;
  int          acc_cyc = 0;
  int          acc_delay = 1;
  int          first_valid = -1;
  int          start_cnt = 0;
  int          last_hs_cyc = 0;
  int          last_lat = 0;
  int          last_starts = 0;
  logic [31:0] last_data = '0;
  logic        last_err = 1'b0;
  logic [11:0] lf = '0;
  logic [31:0] la = '0;
  logic [31:0] lb = '0;
  int          n_cmp = 0;
  int          n_fail = 0;

  // Behavioural ALU: combinational result, ready pulsed acc_delay cycles after start.
  always_comb begin
    alu_c = 32'h0;
    case (alu_funct)
      FUNCT_ADD: alu_c = alu_a + alu_b;
      FUNCT_SUB: alu_c = alu_a - alu_b;
      FUNCT_MUL: alu_c = alu_a * alu_b;
      FUNCT_DIV: alu_c = (alu_b == 32'h0) ? 32'hFFFF_FFFF : alu_a / alu_b;
      FUNCT_REM: alu_c = (alu_b == 32'h0) ? alu_a : alu_a % alu_b;
      default:   alu_c = 32'hDEAD_BEEF;
    endcase
  end

  int ready_at = -1;
  always @(posedge clk) begin
    #1;
    if (!reset) ready_at = -1;
    else if (alu_start) ready_at = cyc + acc_delay;
    alu_ready = stray_ready || ((ready_at >= 0) && (ready_at == cyc));
  end

  always @(posedge clk) begin
    #1;
    out_ready = or_rand ? ($urandom_range(0, 3) != 0) : or_val;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Result of one operation from the architectural rules; d is the ALU delay
  // in cycles from start to ready (0 means ready during EXEC, which is ignored).
  function automatic exp_t model(input logic [11:0] f, input logic [31:0] a,
                                 input logic [31:0] b, input logic [TAG_W-1:0] t,
                                 input int d);
    exp_t m;
    bit   in_time;
    in_time  = (d >= 1) && (d <= TIMEOUT);
    m.tag    = t;
    m.starts = 0;
    m.lat    = 2;
    m.err    = 1'b1;
    m.data   = 32'h0;
    if (f == FUNCT_ADD) begin
      m.data = a + b; m.err = 1'b0;
    end else if (f == FUNCT_SUB) begin
      m.data = a - b; m.err = 1'b0;
    end else if ((f == FUNCT_DIV || f == FUNCT_REM) && b == 32'h0) begin
      m.data = (f == FUNCT_DIV) ? 32'hFFFF_FFFF : a;
    end else if (f == FUNCT_MUL || f == FUNCT_DIV || f == FUNCT_REM) begin
      m.starts = 1;
      if (in_time) begin
        m.lat = d + 2;
        m.err = 1'b0;
        if (f == FUNCT_MUL) m.data = a * b;
        else if (f == FUNCT_DIV) m.data = a / b;
        else m.data = a % b;
      end else begin
        m.lat = TIMEOUT + 2;
      end
    end
    return m;
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!reset) begin
        busy = 1'b0;
        exp_q.delete();
        lf = '0; la = '0; lb = '0;
      end else begin
        bit   due;
        exp_t e;
        due = 1'b0;
        if (busy) begin
          e   = exp_q[0];
          due = (cyc >= acc_cyc + e.lat);
        end
        chk("in_ready", 32'(in_ready), 32'(!busy));
        chk("dbg_idle", 32'(dbg_state == IDLE), 32'(!busy));
        chk("out_valid", 32'(out_valid), 32'(due));
        chk("alu_start", 32'(alu_start), 32'(busy && e.starts == 1 && cyc == acc_cyc + 1));
        chk("alu_funct", 32'(alu_funct), 32'(lf));
        chk("alu_a", alu_a, la);
        chk("alu_b", alu_b, lb);
        if (busy && alu_start) start_cnt++;
        if (busy && out_valid && first_valid < 0) first_valid = cyc;
        if (due) begin
          chk("out_data", out_data, e.data);
          chk("out_tag", 32'(out_tag), 32'(e.tag));
          chk("out_err", 32'(out_err), 32'(e.err));
        end
        if (due && out_ready) begin
          last_data   = out_data;
          last_err    = out_err;
          last_lat    = first_valid - acc_cyc;
          last_starts = start_cnt;
          last_hs_cyc = cyc;
          void'(exp_q.pop_front());
          busy = 1'b0;
        end else if (!busy && in_valid) begin
          exp_q.push_back(model(in_funct, in_a, in_b, in_tag, cur_delay));
          acc_cyc     = cyc;
          acc_delay   = cur_delay;
          lf = in_funct; la = in_a; lb = in_b;
          start_cnt   = 0;
          first_valid = -1;
          busy        = 1'b1;
        end
      end
    end
  endtask

  task automatic issue(input logic [11:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] t, input int d);
    int g;
    g = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_funct = f; in_a = a; in_b = b; in_tag = t; cur_delay = d;
    do begin
      @(negedge clk);
      g++;
    end while (!in_ready && g < 300);
    if (g >= 300) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: in_ready never seen, expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_funct = 12'($urandom); in_a = $urandom; in_b = $urandom;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && g < 300) begin
      @(posedge clk);
      g++;
    end
    if (g >= 300) begin
      n_cmp++; n_fail++;
      $display("FAIL done_timeout: op still busy, expected completion");
    end
  endtask

  task automatic chk_last(input string name, input logic [31:0] d, input logic e,
                          input int lat, input int starts);
    chk({name, "_data"}, last_data, d);
    chk({name, "_err"}, 32'(last_err), 32'(e));
    chk({name, "_lat"}, 32'(last_lat), 32'(lat));
    chk({name, "_starts"}, 32'(last_starts), 32'(starts));
  endtask

  initial begin
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_start", 32'(alu_start), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_alu_funct", 32'(alu_funct), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    @(negedge clk); #2 reset = 1'b1;

    issue(FUNCT_ADD, 32'd5, 32'd7, 5'd3, 1);
    wait_idle();
    chk_last("add", 32'd12, 1'b0, 2, 0);

    issue(FUNCT_MUL, 32'd1000, 32'd3, 5'd4, 33);
    wait_idle();
    chk_last("mul", 32'd3000, 1'b0, 35, 1);

    issue(FUNCT_DIV, 32'd9, 32'd0, 5'd5, 1);
    wait_idle();
    chk_last("div0", 32'hFFFF_FFFF, 1'b1, 2, 0);
    issue(FUNCT_REM, 32'd9, 32'd0, 5'd6, 1);
    wait_idle();
    chk_last("rem0", 32'd9, 1'b1, 2, 0);

    issue(12'h3FF, 32'd1, 32'd2, 5'd7, 1);
    wait_idle();
    chk_last("illegal", 32'd0, 1'b1, 2, 0);

    // Back-pressure, then the next op must be accepted the cycle after IDLE.
    or_val = 1'b0;
    issue(FUNCT_SUB, 32'd10, 32'd3, 5'd8, 1);
    begin
      int g;
      g = 0;
      while (!out_valid && g < 50) begin @(negedge clk); g++; end
    end
    repeat (5) begin
      @(negedge clk);
      chk("bp_data", out_data, 32'd7);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    fork
      issue(FUNCT_ADD, 32'd2, 32'd2, 5'd9, 1);
      begin repeat (2) @(posedge clk); or_val = 1'b1; end
    join
    chk("bp_sub_data", last_data, 32'd7);
    chk("turnaround", 32'(acc_cyc - last_hs_cyc), 32'd1);
    wait_idle();
    chk("bp_add_data", last_data, 32'd4);

    issue(FUNCT_MUL, 32'd7, 32'd6, 5'd10, 1000);
    wait_idle();
    chk_last("timeout", 32'd0, 1'b1, TIMEOUT + 2, 1);
    @(posedge clk); stray_ready = 1'b1;
    repeat (2) @(posedge clk);
    stray_ready = 1'b0;
    @(negedge clk);
    chk("stray_out_valid", 32'(out_valid), 32'd0);
    chk("stray_in_ready", 32'(in_ready), 32'd1);

    issue(FUNCT_MUL, 32'd11, 32'd13, 5'd11, 0);
    wait_idle();
    chk_last("exec_ready", 32'd0, 1'b1, TIMEOUT + 2, 1);
    issue(FUNCT_DIV, 32'd100, 32'd7, 5'd12, TIMEOUT);
    wait_idle();
    chk_last("ready_at_tc", 32'd14, 1'b0, TIMEOUT + 2, 1);
    issue(FUNCT_REM, 32'd100, 32'd7, 5'd13, TIMEOUT + 1);
    wait_idle();
    chk_last("ready_late", 32'd0, 1'b1, TIMEOUT + 2, 1);

    // Asynchronous reset in the middle of WAIT.
    issue(FUNCT_MUL, 32'd3, 32'd3, 5'd14, 50);
    repeat (10) @(posedge clk);
    @(negedge clk); #2 reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_alu_start", 32'(alu_start), 32'd0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    issue(FUNCT_ADD, 32'd1, 32'd1, 5'd15, 1);
    wait_idle();
    chk_last("post_rst_add", 32'd2, 1'b0, 2, 0);

    or_rand = 1'b1;
    for (int n = 0; n < 60; n++) begin
      logic [11:0] f;
      logic [31:0] b;
      int          d;
      int          sel;
      sel = $urandom_range(0, 5);
      case (sel)
        0: f = FUNCT_ADD;
        1: f = FUNCT_SUB;
        2: f = FUNCT_MUL;
        3: f = FUNCT_DIV;
        4: f = FUNCT_REM;
        default: begin
          f = 12'($urandom);
          while (is_single_cycle(f) || is_multicycle(f)) f = 12'($urandom);
        end
      endcase
      b = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      case ($urandom_range(0, 9))
        0: d = 0;
        1: d = TIMEOUT;
        2: d = TIMEOUT + 1;
        3: d = TIMEOUT - 1;
        default: d = $urandom_range(1, 40);
      endcase
      issue(f, $urandom, b, 5'($urandom), d);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Issue/sequencing stage directly upstream of the ALU.
- Accepts one decoded operation per transaction from the decode stage over a valid/ready handshake, and holds funct and operands stable on the ALU inputs.
- Pulses a start for the multi-cycle units (multiply, divide), waits for the ALU's ready, and captures the 32-bit result.
- Presents the captured result to writeback over a second valid/ready handshake.
- Keeps only one operation in flight; multi-cycle latency is hidden from decode by back-pressure.

Parameters:
- TIMEOUT, 64, maximum cycles to wait for alu_ready on a multi-cycle op before aborting with an error.
- TAG_W, 5, width of the destination-register tag carried alongside the operation.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  decode presents an operation.
- in_ready  out  1  block can accept an operation.
- in_funct  in  12  ALU function code.
- in_a  in  32  operand A.
- in_b  in  32  operand B.
- in_tag  in  TAG_W  destination register tag.
- alu_funct  out  12  registered funct to ALU.
- alu_a  out  32  registered operand A to ALU.
- alu_b  out  32  registered operand B to ALU.
- alu_start  out  1  one-cycle start pulse for multi-cycle ops.
- alu_c  in  32  ALU result.
- alu_ready  in  1  multi-cycle unit result valid.
- out_valid  out  1  result available to writeback.
- out_ready  in  1  writeback accepts result.
- out_data  out  32  captured result.
- out_tag  out  TAG_W  tag of the result.
- out_err  out  1  result is an error (bad funct, divide by zero, timeout).

Behaviour:
- Reset (reset=0, async): state=IDLE, in_ready=1, out_valid=0, alu_start=0, out_err=0; out_data, out_tag, alu_funct, alu_a, alu_b all 0; timeout counter 0.
- Function codes are classified by the package constants:
  - ADD, SUB: single-cycle.
  - MUL, DIV, REM: multi-cycle.
  - Any other value: illegal.
- State IDLE: in_ready=1.
  - On in_valid&in_ready, latch funct/a/b/tag into the alu_* and tag registers, then go to EXEC.
- State EXEC (one cycle): in_ready=0. Exit depends on the op class:
  - Single-cycle: capture alu_c into out_data, err=0, go to DONE. Accept-to-out_valid latency is 2 cycles.
  - Illegal funct: out_data=0, err=1, go to DONE. alu_start stays 0.
  - DIV/REM with b==0: out_data=32'hFFFFFFFF for DIV and a for REM, err=1, go to DONE. alu_start stays 0.
  - Other multi-cycle ops: alu_start=1 for this cycle only, clear the counter, go to WAIT.
- State WAIT: alu_start=0. The counter increments each cycle.
  - alu_ready is only sampled from the first WAIT cycle on; alu_ready asserted during EXEC is ignored.
  - alu_ready=1: capture alu_c (MUL returns the low 32 bits as presented by the ALU), err=0, go to DONE.
  - Counter reaches TIMEOUT-1 with no ready: out_data=0, err=1, go to DONE.
  - If alu_ready and the timeout coincide, ready wins.
- State DONE: out_valid=1. out_data, out_tag and out_err are held stable while out_valid=1 and out_ready=0.
  - On out_ready=1: out_valid drops the next cycle and the block returns to IDLE. A new accept is possible one cycle later; there is no same-cycle turnaround.
- alu_funct, alu_a and alu_b hold their last values after completion; they are not cleared.
- in_ready is deasserted in all states except IDLE.
- Asserting reset mid-operation from any state returns the block to IDLE immediately and drops out_valid. No result is emitted, and a pending ALU op is abandoned; the ALU shares the same reset.
- in_valid while in_ready=0 has no effect; decode must hold its inputs stable until accepted.

Decomposition:
- Package alu_pkg holds the following, to be reused by the ALU decode and writeback:
  - Localparams FUNCT_ADD=12'h020, FUNCT_SUB=12'h022, FUNCT_MUL=12'h018, FUNCT_DIV=12'h01A, FUNCT_REM=12'h01B.
  - State encoding IDLE/EXEC/WAIT/DONE (2 bits).
  - Helper function is_multicycle(funct).
- One sub-module, alu_issue_timer: loadable up-counter with a terminal-count flag parameterised by TIMEOUT.

Test Plan:
- Single-cycle ADD: in_funct=020, a=5, b=7, out_ready=1 -> out_valid 2 cycles after accept, out_data=12, err=0, alu_start never 1.
- MUL: a=1000, b=3; ALU model asserts alu_ready 33 cycles after alu_start -> exactly one alu_start pulse, in_ready=0 throughout, out_data=3000, err=0.
- DIV by zero: funct=01A, a=9, b=0 -> no alu_start, out_data=FFFFFFFF, err=1. Repeat with REM -> out_data=9, err=1.
- Back-pressure: complete a SUB 10-3 with out_ready=0 for 5 cycles -> out_valid and out_data=7 stable, in_ready=0. When out_ready=1, IDLE the next cycle and the next op is accepted.
- Timeout: MUL with alu_ready never asserted, TIMEOUT=64 -> out_valid after 64 WAIT cycles, err=1, data=0. Then a stray alu_ready in IDLE is ignored.
- Reset mid-WAIT: drive reset=0 asynchronously during WAIT -> out_valid=0 and in_ready=1 immediately. After release, the next ADD 1+1 returns 2.
